// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the single-port SRAM model:
//   - sram_state_e : controller state (CLEAR = zero-fill running, IDLE = serving)
//   - DEF_*        : default parameter values used by sram_sp_param
// -----------------------------------------------------------------------------
package sram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } sram_state_e;

   localparam int DEF_ADDRESSSIZE    = 15;
   localparam int DEF_ADDRESSBITSIZE = 32768;
   localparam int DEF_WORDSIZE       = 64;
   localparam int DEF_RDLATENCY      = 1;
   localparam int DEF_CLEARONRESET   = 1;

endpackage

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
// RDLATENCY-deep data/valid shift register carrying read results to Q.
// Ports:
//   iClk   : clock, rising edge
//   iClr   : synchronous clear, active-high (drops in-flight reads, zeroes data)
//   iVld   : a read word is presented this cycle
//   iData  : read word
//   oVld   : one-cycle pulse when oData carries a new word
//   oData  : delivered word; holds its last value between deliveries
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
   parameter int WORDSIZE  = 64,
   parameter int RDLATENCY = 1
) (
   input  logic                iClk,
   input  logic                iClr,
   input  logic                iVld,
   input  logic [WORDSIZE-1:0] iData,
   output logic                oVld,
   output logic [WORDSIZE-1:0] oData
);

   logic [RDLATENCY-1:0] vld_q;
   logic [WORDSIZE-1:0]  dat_q [RDLATENCY];

   // Data stages only load when a valid word arrives, so the last stage
   // naturally holds the previous result between reads.
   always_ff @(posedge iClk) begin
      if (iClr) begin
         vld_q <= '0;
         for (int i = 0; i < RDLATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= iVld;
         if (iVld) begin
            dat_q[0] <= iData;
         end
         for (int i = 1; i < RDLATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign oVld  = vld_q[RDLATENCY-1];
   assign oData = dat_q[RDLATENCY-1];

endmodule

// File: rtl/sram_sp_param.sv
// -----------------------------------------------------------------------------
// sram_sp_param
// Parameterised single-port SRAM with byte enables, pipelined reads and an
// optional zero-fill of the whole array after reset.
// Ports:
//   iClk    : clock, rising edge
//   iReset  : synchronous reset, active-low
//   CSN     : chip select, active-low
//   WEN     : write enable, active-low (1 with CSN=0 is a read)
//   BE      : byte write enables, bit i covers D[8i+7:8i]
//   A       : word address (addresses >= ADDRESSBITSIZE read as 0, writes dropped)
//   D       : write data
//   Q       : registered read data, RDLATENCY cycles after the read command
//   oQValid : one-cycle pulse when Q carries new read data
//   oBusy   : high while the zero-fill runs; port commands are ignored then
// -----------------------------------------------------------------------------
module sram_sp_param
   import sram_pkg::*;
#(
   parameter int ADDRESSSIZE    = DEF_ADDRESSSIZE,
   parameter int ADDRESSBITSIZE = DEF_ADDRESSBITSIZE,
   parameter int WORDSIZE       = DEF_WORDSIZE,
   parameter int RDLATENCY      = DEF_RDLATENCY,
   parameter int CLEARONRESET   = DEF_CLEARONRESET
) (
   input  logic                    iClk,
   input  logic                    iReset,
   input  logic                    CSN,
   input  logic                    WEN,
   input  logic [WORDSIZE/8-1:0]   BE,
   input  logic [ADDRESSSIZE-1:0]  A,
   input  logic [WORDSIZE-1:0]     D,
   output logic [WORDSIZE-1:0]     Q,
   output logic                    oQValid,
   output logic                    oBusy
);

   localparam int NB = WORDSIZE / 8;
   localparam int IW = (ADDRESSBITSIZE > 1) ? $clog2(ADDRESSBITSIZE) : 1;
   localparam logic [ADDRESSSIZE:0] DEPTH = (ADDRESSSIZE + 1)'(ADDRESSBITSIZE);
   localparam logic [IW-1:0]        LAST  = IW'(ADDRESSBITSIZE - 1);

   logic [WORDSIZE-1:0] Mem [0:ADDRESSBITSIZE-1];

   sram_state_e   state_q, state_d;
   logic [IW-1:0] fill_q, fill_d;

   logic          in_range;
   logic [IW-1:0] a_idx;
   logic          fill_we, wr_en, rd_en;
   logic [WORDSIZE-1:0] rd_word;

   assign in_range = ({1'b0, A} < DEPTH);
   assign a_idx    = A[IW-1:0];
   assign rd_word  = in_range ? Mem[a_idx] : '0;

   // State register
   always_ff @(posedge iClk) begin
      if (!iReset) begin
         state_q <= (CLEARONRESET != 0) ? CLEAR : IDLE;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   // Next state: walk the fill counter, leave CLEAR after the last word
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      case (state_q)
         CLEAR: begin
            if (fill_q == LAST) begin
               state_d = IDLE;
               fill_d  = '0;
            end else begin
               fill_d  = fill_q + IW'(1);
            end
         end
         default: ;
      endcase
   end

   // Outputs / strobes. Port commands only act in IDLE and never while
   // reset is held, so a write cannot sneak in on a reset edge.
   always_comb begin
      oBusy   = 1'b0;
      fill_we = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         CLEAR: begin
            oBusy   = 1'b1;
            fill_we = iReset;
         end
         IDLE: begin
            wr_en = iReset && !CSN && !WEN && in_range;
            rd_en = iReset && !CSN && WEN;
         end
         default: ;
      endcase
   end

   // Storage: no reset on the array itself
   always_ff @(posedge iClk) begin
      if (fill_we) begin
         Mem[fill_q] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (BE[i]) begin
               Mem[a_idx][8*i +: 8] <= D[8*i +: 8];
            end
         end
      end
   end

   sram_rd_pipe #(
      .WORDSIZE  (WORDSIZE),
      .RDLATENCY (RDLATENCY)
   ) u_rd_pipe (
      .iClk  (iClk),
      .iClr  (!iReset),
      .iVld  (rd_en),
      .iData (rd_word),
      .oVld  (oQValid),
      .oData (Q)
   );

endmodule
